// File: rtl/wb_arbiter_pkg.sv
// Shared widths, the writeback packet type and the saturating counter helper
// used by the writeback arbiter.
package wb_arbiter_pkg;

    localparam int ROB_W   = 6;
    localparam int PHYS_W  = 7;
    localparam int EPOCH_W = 3;
    localparam int CNT_W   = 16;

    // One writeback result as produced by an execution unit.
    typedef struct packed {
        logic [31:0]        pc;
        logic               uses_rd;
        logic [ROB_W-1:0]   rob_idx;
        logic [PHYS_W-1:0]  prd_new;
        logic [EPOCH_W-1:0] epoch;
        logic [31:0]        data;
    } wb_pkt_t;

    // Add inc to cnt, clamping at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester found when walking
// upward from ptr (wrapping at N) receives the one-hot grant.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             any_gnt
);

    // Walk the requesters in priority order starting at ptr; first hit wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        gnt     = '0;
        any_gnt = 1'b0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!any_gnt && req[PTR_W'(idx)]) begin
                gnt[PTR_W'(idx)] = 1'b1;
                any_gnt          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: drops results from stale epochs, picks one live result
// per cycle round-robin and broadcasts it on the CDB one cycle later.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NSRC    = 3,
    parameter int ROB_W   = wb_arbiter_pkg::ROB_W,
    parameter int PHYS_W  = wb_arbiter_pkg::PHYS_W,
    parameter int EPOCH_W = wb_arbiter_pkg::EPOCH_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NSRC-1:0]                src_valid,
    output logic [NSRC-1:0]                src_ready,
    input  logic [NSRC-1:0][31:0]          src_pc,
    input  logic [NSRC-1:0]                src_uses_rd,
    input  logic [NSRC-1:0][ROB_W-1:0]     src_rob_idx,
    input  logic [NSRC-1:0][PHYS_W-1:0]    src_prd_new,
    input  logic [NSRC-1:0][EPOCH_W-1:0]   src_epoch,
    input  logic [NSRC-1:0][31:0]          src_data,
    input  logic                           flush_valid,
    input  logic [EPOCH_W-1:0]             flush_epoch,
    output logic                           cdb_valid,
    output logic [31:0]                    cdb_pc,
    output logic                           cdb_uses_rd,
    output logic [ROB_W-1:0]               cdb_rob_idx,
    output logic [PHYS_W-1:0]              cdb_prd_new,
    output logic [31:0]                    cdb_data,
    output logic [1:0]                     cdb_src,
    output logic                           prf_we,
    output logic [15:0]                    drop_count
);

    localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [EPOCH_W-1:0] cur_epoch;
    logic [PTR_W-1:0]   rr_ptr;
    logic [NSRC-1:0]    stale;
    logic [NSRC-1:0]    req;
    logic [NSRC-1:0]    gnt;
    logic               any_gnt;
    logic [PTR_W-1:0]   win_sel;
    logic [CNT_W-1:0]   n_stale;

    // Classify sources, build the request vector and the handshake, count drops.
    always_comb begin
        stale   = '0;
        n_stale = '0;
        win_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            stale[i] = src_valid[i] && ((src_epoch[i] != cur_epoch) || flush_valid);
            if (stale[i]) n_stale = n_stale + 16'd1;
            if (gnt[i])   win_sel = PTR_W'(i);
        end
        // Nothing is accepted while in reset, so a request there is simply lost.
        req       = rst ? '0 : (src_valid & ~stale);
        src_ready = rst ? '0 : (stale | gnt);
    end

    rr_arbiter #(
        .N     (NSRC),
        .PTR_W (PTR_W)
    ) u_rr (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .any_gnt (any_gnt)
    );

    // Register the winner's payload, advance the pointer, track epoch and drops.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            cdb_valid   <= 1'b0;
            cdb_pc      <= '0;
            cdb_uses_rd <= 1'b0;
            cdb_rob_idx <= '0;
            cdb_prd_new <= '0;
            cdb_data    <= '0;
            cdb_src     <= '0;
            rr_ptr      <= '0;
            cur_epoch   <= '0;
            drop_count  <= '0;
        end else begin
            cdb_valid <= any_gnt;
            if (any_gnt) begin
                cdb_pc      <= src_pc[win_sel];
                cdb_uses_rd <= src_uses_rd[win_sel];
                cdb_rob_idx <= src_rob_idx[win_sel];
                cdb_prd_new <= src_prd_new[win_sel];
                cdb_data    <= src_data[win_sel];
                cdb_src     <= 2'(win_sel);
                rr_ptr      <= (int'(win_sel) == NSRC - 1) ? '0 : win_sel + 1'b1;
            end
            if (flush_valid) cur_epoch <= flush_epoch;
            drop_count <= sat_add(drop_count, n_stale);
        end
    end

    assign prf_we = cdb_valid && cdb_uses_rd;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NSRC = 3;

    logic                          clk;
    logic                          rst;
    logic [NSRC-1:0]               src_valid;
    logic [NSRC-1:0]               src_ready;
    logic [NSRC-1:0][31:0]         src_pc;
    logic [NSRC-1:0]               src_uses_rd;
    logic [NSRC-1:0][ROB_W-1:0]    src_rob_idx;
    logic [NSRC-1:0][PHYS_W-1:0]   src_prd_new;
    logic [NSRC-1:0][EPOCH_W-1:0]  src_epoch;
    logic [NSRC-1:0][31:0]         src_data;
    logic                          flush_valid;
    logic [EPOCH_W-1:0]            flush_epoch;
    logic                          cdb_valid;
    logic [31:0]                   cdb_pc;
    logic                          cdb_uses_rd;
    logic [ROB_W-1:0]              cdb_rob_idx;
    logic [PHYS_W-1:0]             cdb_prd_new;
    logic [31:0]                   cdb_data;
    logic [1:0]                    cdb_src;
    logic                          prf_we;
    logic [15:0]                   drop_count;

    wb_arbiter #(.NSRC(NSRC)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_pc      (src_pc),
        .src_uses_rd (src_uses_rd),
        .src_rob_idx (src_rob_idx),
        .src_prd_new (src_prd_new),
        .src_epoch   (src_epoch),
        .src_data    (src_data),
        .flush_valid (flush_valid),
        .flush_epoch (flush_epoch),
        .cdb_valid   (cdb_valid),
        .cdb_pc      (cdb_pc),
        .cdb_uses_rd (cdb_uses_rd),
        .cdb_rob_idx (cdb_rob_idx),
        .cdb_prd_new (cdb_prd_new),
        .cdb_data    (cdb_data),
        .cdb_src     (cdb_src),
        .prf_we      (prf_we),
        .drop_count  (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model state: current epoch, where the next search starts, drop total,
    // and the broadcast currently on the CDB.
    logic [EPOCH_W-1:0] m_epoch;
    int                 m_start;
    int                 m_drops;
    bit                 m_valid;
    wb_pkt_t            m_pkt;
    int                 m_src;
    logic [NSRC-1:0]    exp_ready;
    logic [NSRC-1:0]    last_ready;
    int                 exp_win;
    int                 exp_nstale;

    // Decide, from the current inputs, who is dropped and who wins this cycle.
    task automatic model_comb();
        bit live [NSRC];
        exp_ready  = '0;
        exp_win    = -1;
        exp_nstale = 0;
        if (rst) return;
        for (int i = 0; i < NSRC; i++) begin
            bit st;
            st = src_valid[i] && (flush_valid || src_epoch[i] != m_epoch);
            live[i] = src_valid[i] && !st;
            if (st) begin
                exp_ready[i] = 1'b1;
                exp_nstale++;
            end
        end
        for (int k = 0; k < NSRC; k++) begin
            int j;
            j = (m_start + k) % NSRC;
            if (exp_win < 0 && live[j]) exp_win = j;
        end
        if (exp_win >= 0) exp_ready[exp_win] = 1'b1;
    endtask

    // Advance the model across a rising edge.
    task automatic model_update();
        if (rst) begin
            m_epoch = '0;
            m_start = 0;
            m_drops = 0;
            m_valid = 0;
            m_pkt   = '0;
            m_src   = 0;
            return;
        end
        m_valid = (exp_win >= 0);
        if (exp_win >= 0) begin
            m_pkt.pc      = src_pc[exp_win];
            m_pkt.uses_rd = src_uses_rd[exp_win];
            m_pkt.rob_idx = src_rob_idx[exp_win];
            m_pkt.prd_new = src_prd_new[exp_win];
            m_pkt.data    = src_data[exp_win];
            m_src         = exp_win;
            m_start       = (exp_win + 1) % NSRC;
        end
        if (flush_valid) m_epoch = flush_epoch;
        m_drops = m_drops + exp_nstale;
        if (m_drops > 65535) m_drops = 65535;
    endtask

    // One clock cycle: inputs were driven at the falling edge by the caller.
    task automatic tick();
        model_comb();
        #1;
        check("src_ready", 64'(src_ready), 64'(exp_ready));
        last_ready = exp_ready;
        @(posedge clk);
        model_update();
        #1;
        check("cdb_valid",   64'(cdb_valid),   64'(m_valid));
        check("cdb_pc",      64'(cdb_pc),      64'(m_pkt.pc));
        check("cdb_uses_rd", 64'(cdb_uses_rd), 64'(m_pkt.uses_rd));
        check("cdb_rob_idx", 64'(cdb_rob_idx), 64'(m_pkt.rob_idx));
        check("cdb_prd_new", 64'(cdb_prd_new), 64'(m_pkt.prd_new));
        check("cdb_data",    64'(cdb_data),    64'(m_pkt.data));
        check("cdb_src",     64'(cdb_src),     64'(m_src));
        check("prf_we",      64'(prf_we),      64'(m_valid && m_pkt.uses_rd));
        check("drop_count",  64'(drop_count),  64'(m_drops));
        @(negedge clk);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_srcs();
        src_valid   = '0;
        src_pc      = '0;
        src_uses_rd = '0;
        src_rob_idx = '0;
        src_prd_new = '0;
        src_epoch   = '0;
        src_data    = '0;
        flush_valid = 1'b0;
        flush_epoch = '0;
    endtask

    task automatic set_src(input int i, input logic [31:0] data,
                           input logic [EPOCH_W-1:0] ep, input bit uses);
        src_valid[i]   = 1'b1;
        src_data[i]    = data;
        src_pc[i]      = 32'h1000_0000 + data;
        src_uses_rd[i] = uses;
        src_rob_idx[i] = ROB_W'(i + 5);
        src_prd_new[i] = PHYS_W'(i + 9);
        src_epoch[i]   = ep;
    endtask

    task automatic do_reset();
        clear_srcs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Random source: hold an unaccepted result, otherwise maybe offer a new one.
    task automatic rand_drive();
        for (int i = 0; i < NSRC; i++) begin
            if (!(src_valid[i] && !last_ready[i])) begin
                src_valid[i]   = ($urandom_range(0, 99) < 60);
                src_pc[i]      = $urandom;
                src_data[i]    = $urandom;
                src_uses_rd[i] = 1'($urandom);
                src_rob_idx[i] = ROB_W'($urandom);
                src_prd_new[i] = PHYS_W'($urandom);
                src_epoch[i]   = ($urandom_range(0, 7) == 0) ? EPOCH_W'($urandom) : m_epoch;
            end
        end
        flush_valid = ($urandom_range(0, 29) == 0);
        flush_epoch = EPOCH_W'($urandom);
        rst         = ($urandom_range(0, 199) == 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        last_ready = '0;
        clear_srcs();
        rst = 1'b1;

        // Grant attempted during reset is lost; first post-reset grant starts at 0.
        set_src(1, 32'h0000_00B1, '0, 1'b1);
        tick();
        #1 check("reset_ready", 64'(src_ready), 64'd0);
        tick();
        rst = 1'b0;
        clear_srcs();
        tick();
        check("post_reset_no_cdb", 64'(cdb_valid), 64'd0);
        check("post_reset_drops", 64'(drop_count), 64'd0);
        set_src(0, 32'h0000_00A0, '0, 1'b1);
        set_src(1, 32'h0000_00B0, '0, 1'b1);
        set_src(2, 32'h0000_00C0, '0, 1'b0);
        tick();
        check("first_grant_src0", 64'(cdb_src), 64'd0);

        // ALU alone.
        clear_srcs();
        set_src(0, 32'h0000_1234, '0, 1'b1);
        #1 check("alu_ready", 64'(src_ready), 64'b001);
        tick();
        check("alu_cdb_valid", 64'(cdb_valid), 64'd1);
        check("alu_cdb_data", 64'(cdb_data), 64'h1234);
        check("alu_cdb_src", 64'(cdb_src), 64'd0);
        check("alu_prf_we", 64'(prf_we), 64'd1);

        // All three valid for three cycles: 0, 1, 2, losers holding payload.
        do_reset();
        set_src(0, 32'h0000_00A0, '0, 1'b1);
        set_src(1, 32'h0000_00B0, '0, 1'b1);
        set_src(2, 32'h0000_00C0, '0, 1'b0);
        #1 check("rr_ready0", 64'(src_ready), 64'b001);
        tick();
        check("rr_src0", 64'(cdb_src), 64'd0);
        check("rr_data0", 64'(cdb_data), 64'hA0);
        set_src(0, 32'h0000_01A0, '0, 1'b1);
        #1 check("rr_ready1", 64'(src_ready), 64'b010);
        tick();
        check("rr_src1", 64'(cdb_src), 64'd1);
        check("rr_data1", 64'(cdb_data), 64'hB0);
        set_src(1, 32'h0000_01B0, '0, 1'b1);
        #1 check("rr_ready2", 64'(src_ready), 64'b100);
        tick();
        check("rr_src2", 64'(cdb_src), 64'd2);
        check("rr_data2", 64'(cdb_data), 64'hC0);
        check("rr_prf_we2", 64'(prf_we), 64'd0);

        // LSU with a future epoch is dropped.
        do_reset();
        set_src(2, 32'h0000_0777, 3'd1, 1'b1);
        #1 check("stale_ready", 64'(src_ready), 64'b100);
        tick();
        check("stale_no_cdb", 64'(cdb_valid), 64'd0);
        check("stale_drops", 64'(drop_count), 64'd1);

        // Flush: broadcast in flight completes, both sources dropped, epoch moves.
        clear_srcs();
        set_src(0, 32'h0000_0055, '0, 1'b1);
        tick();
        set_src(0, 32'h0000_0066, '0, 1'b1);
        set_src(1, 32'h0000_0067, '0, 1'b1);
        flush_valid = 1'b1;
        flush_epoch = 3'd1;
        #1 check("flush_ready", 64'(src_ready), 64'b011);
        check("flush_cycle_cdb", 64'(cdb_valid), 64'd1);
        tick();
        check("after_flush_cdb", 64'(cdb_valid), 64'd0);
        check("flush_drops", 64'(drop_count), 64'd3);
        clear_srcs();
        set_src(0, 32'h0000_0088, '0, 1'b1);
        #1 check("old_epoch_ready", 64'(src_ready), 64'b001);
        tick();
        check("old_epoch_no_cdb", 64'(cdb_valid), 64'd0);
        check("old_epoch_drops", 64'(drop_count), 64'd4);
        set_src(0, 32'h0000_0099, 3'd1, 1'b1);
        tick();
        check("new_epoch_cdb", 64'(cdb_valid), 64'd1);
        check("new_epoch_data", 64'(cdb_data), 64'h99);

        // Saturation: drive drop_count up to 0xFFFC, then past the top.
        do_reset();
        for (int i = 0; i < NSRC; i++) set_src(i, 32'(i), '0, 1'b0);
        flush_valid = 1'b1;
        for (int n = 0; n < 21844; n++) tick();
        check("sat_preset", 64'(drop_count), 64'hFFFC);
        tick();
        check("sat_reach", 64'(drop_count), 64'hFFFF);
        tick();
        check("sat_hold", 64'(drop_count), 64'hFFFF);

        // Randomized traffic.
        do_reset();
        last_ready = '0;
        for (int n = 0; n < 4000; n++) begin
            rand_drive();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
